// File: rtl/receiver_controlreg.sv
// Host control/status register block for the I2C receive path: holds burst configuration,
// counts bytes from the receiver engine and answers each byte with ACK or NACK.
module receiver_controlreg (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Rdata,
    input  logic [1:0] Raddr,
    input  logic       Rwrite,
    output logic [7:0] dataout,
    input  logic       rx_valid,
    output logic       rx_ack,
    output logic       rx_nack,
    output logic       beat_end,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RECEIVING = 2'd1;
    localparam logic [1:0] DONE      = 2'd2;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_SIZE  = 2'd1;
    localparam logic [1:0] ADDR_BURST = 2'd2;
    localparam logic [1:0] ADDR_STAT  = 2'd3;

    logic [1:0] state, state_d;
    logic [7:0] rsize, rsize_d, rburst, rburst_d;
    logic [7:0] byte_cnt, byte_cnt_d, beat_cnt, beat_cnt_d;
    logic [7:0] dataout_d;
    logic       overflow, overflow_d, cfg_err, cfg_err_d;
    logic       ack_d, nack_d, beat_end_d;

    logic       ctrl_wr, start, abort, clr;
    logic       cfg_ok, last_byte, last_beat;
    logic [7:0] status;

    assign ctrl_wr   = Rwrite && (Raddr == ADDR_CTRL);
    assign start     = ctrl_wr && Rdata[0];
    assign abort     = ctrl_wr && Rdata[1];
    assign clr       = ctrl_wr && Rdata[2];
    assign cfg_ok    = (rsize != 8'd0) && (rburst != 8'd0);
    assign last_byte = (byte_cnt == rsize - 8'd1);
    assign last_beat = (beat_cnt == rburst - 8'd1);
    assign status    = {4'b0000, cfg_err, overflow, done, busy};

    // Next-state, counter, register-file and pulse logic.
    always_comb begin
        state_d    = state;
        rsize_d    = rsize;
        rburst_d   = rburst;
        byte_cnt_d = byte_cnt;
        beat_cnt_d = beat_cnt;
        overflow_d = overflow;
        cfg_err_d  = cfg_err;
        dataout_d  = dataout;
        ack_d      = 1'b0;
        nack_d     = 1'b0;
        beat_end_d = 1'b0;

        if (Rwrite) begin
            if (state != RECEIVING) begin
                if (Raddr == ADDR_SIZE)  rsize_d  = Rdata;
                if (Raddr == ADDR_BURST) rburst_d = Rdata;
            end
        end else begin
            case (Raddr)
                ADDR_SIZE:  dataout_d = rsize;
                ADDR_BURST: dataout_d = rburst;
                ADDR_STAT:  dataout_d = status;
                default:    dataout_d = 8'd0;
            endcase
        end

        // Clear applies first so that events on the same edge can still set the flags.
        if (clr) begin
            overflow_d = 1'b0;
            cfg_err_d  = 1'b0;
        end

        if (abort) begin
            state_d    = IDLE;
            byte_cnt_d = 8'd0;
            beat_cnt_d = 8'd0;
            nack_d     = rx_valid;
        end else if (state == RECEIVING) begin
            if (rx_valid) begin
                ack_d = 1'b1;
                if (last_byte) begin
                    byte_cnt_d = 8'd0;
                    beat_end_d = 1'b1;
                    if (last_beat) state_d = DONE;
                    else           beat_cnt_d = beat_cnt + 8'd1;
                end else begin
                    byte_cnt_d = byte_cnt + 8'd1;
                end
            end
        end else if (start && cfg_ok) begin
            state_d    = RECEIVING;
            byte_cnt_d = 8'd0;
            beat_cnt_d = 8'd0;
            overflow_d = 1'b0;
            nack_d     = rx_valid;
        end else begin
            if (start) cfg_err_d = 1'b1;
            if (rx_valid) begin
                nack_d     = 1'b1;
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            rsize    <= 8'd0;
            rburst   <= 8'd0;
            byte_cnt <= 8'd0;
            beat_cnt <= 8'd0;
            overflow <= 1'b0;
            cfg_err  <= 1'b0;
            dataout  <= 8'd0;
            rx_ack   <= 1'b0;
            rx_nack  <= 1'b0;
            beat_end <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            rsize    <= rsize_d;
            rburst   <= rburst_d;
            byte_cnt <= byte_cnt_d;
            beat_cnt <= beat_cnt_d;
            overflow <= overflow_d;
            cfg_err  <= cfg_err_d;
            dataout  <= dataout_d;
            rx_ack   <= ack_d;
            rx_nack  <= nack_d;
            beat_end <= beat_end_d;
            busy     <= (state_d == RECEIVING);
            done     <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_receiver_controlreg.sv
// Self-checking bench for receiver_controlreg: vector table plus hand sequences,
// expectations queued at drive time and popped after the DUT's negedge update.
module tb_receiver_controlreg;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Rdata;
    logic [1:0] Raddr;
    logic       Rwrite;
    logic [7:0] dataout;
    logic       rx_valid;
    logic       rx_ack, rx_nack, beat_end, busy, done;

    int checks = 0;
    int errors = 0;

    // flags order: {rx_ack, rx_nack, beat_end, busy, done}
    typedef struct {
        logic       rst;
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        logic       rxv;
        logic [4:0] flags;
        logic       chk_d;
        logic [7:0] exp_d;
    } vec_t;

    typedef struct {
        logic [4:0] flags;
        logic       chk_d;
        logic [7:0] exp_d;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    receiver_controlreg dut (
        .clk      (clk),
        .rst      (rst),
        .Rdata    (Rdata),
        .Raddr    (Raddr),
        .Rwrite   (Rwrite),
        .dataout  (dataout),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .rx_nack  (rx_nack),
        .beat_end (beat_end),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic r, input logic wr, input logic [1:0] addr,
                                input logic [7:0] data, input logic rxv,
                                input logic [4:0] flags, input logic chk_d,
                                input logic [7:0] exp_d);
        vec_t v;
        v.rst = r; v.wr = wr; v.addr = addr; v.data = data; v.rxv = rxv;
        v.flags = flags; v.chk_d = chk_d; v.exp_d = exp_d;
        return v;
    endfunction

    // Drive one vector after posedge, let the DUT update on negedge, then check.
    task automatic step(input vec_t v, input string name);
        exp_t e;
        logic [4:0] got;
        @(posedge clk);
        rst      = v.rst;
        Rwrite   = v.wr;
        Raddr    = v.addr;
        Rdata    = v.data;
        rx_valid = v.rxv;
        e.flags = v.flags; e.chk_d = v.chk_d; e.exp_d = v.exp_d; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        #1;
        e = sb.pop_front();
        got = {rx_ack, rx_nack, beat_end, busy, done};
        checks++;
        if (got !== e.flags) begin
            errors++;
            $display("FAIL %s flags{ack,nack,be,busy,done}: got %b expected %b", e.name, got, e.flags);
        end
        if (e.chk_d) begin
            checks++;
            if (dataout !== e.exp_d) begin
                errors++;
                $display("FAIL %s dataout: got %02h expected %02h", e.name, dataout, e.exp_d);
            end
        end
    endtask

    initial begin
        rst = 1'b0; Rwrite = 1'b0; Raddr = 2'd0; Rdata = 8'd0; rx_valid = 1'b0;

        // reset with junk inputs
        tbl.push_back(mk(0, 1, 2'd1, 8'hFF, 1, 5'b00000, 1, 8'h00));
        tbl.push_back(mk(0, 1, 2'd2, 8'hA5, 1, 5'b00000, 1, 8'h00));
        tbl.push_back(mk(1, 0, 2'd3, 8'h00, 0, 5'b00000, 1, 8'h00));
        // basic burst: Rsize=3, Rburst=2
        tbl.push_back(mk(1, 1, 2'd1, 8'h03, 0, 5'b00000, 0, 8'h00));
        tbl.push_back(mk(1, 1, 2'd2, 8'h02, 0, 5'b00000, 0, 8'h00));
        tbl.push_back(mk(1, 0, 2'd1, 8'h00, 0, 5'b00000, 1, 8'h03));
        tbl.push_back(mk(1, 1, 2'd0, 8'h01, 0, 5'b00010, 0, 8'h00));
        tbl.push_back(mk(1, 0, 2'd0, 8'h00, 1, 5'b10010, 1, 8'h00));
        tbl.push_back(mk(1, 0, 2'd0, 8'h00, 1, 5'b10010, 1, 8'h00));
        tbl.push_back(mk(1, 0, 2'd0, 8'h00, 1, 5'b10110, 1, 8'h00));
        tbl.push_back(mk(1, 0, 2'd0, 8'h00, 1, 5'b10010, 1, 8'h00));
        tbl.push_back(mk(1, 0, 2'd0, 8'h00, 1, 5'b10010, 1, 8'h00));
        tbl.push_back(mk(1, 0, 2'd0, 8'h00, 1, 5'b10101, 1, 8'h00));
        tbl.push_back(mk(1, 0, 2'd3, 8'h00, 0, 5'b00001, 1, 8'h02));
        // overflow then clear
        tbl.push_back(mk(1, 0, 2'd3, 8'h00, 1, 5'b01001, 1, 8'h02));
        tbl.push_back(mk(1, 0, 2'd3, 8'h00, 0, 5'b00001, 1, 8'h06));
        tbl.push_back(mk(1, 1, 2'd0, 8'h04, 0, 5'b00001, 0, 8'h00));
        tbl.push_back(mk(1, 0, 2'd3, 8'h00, 0, 5'b00001, 1, 8'h02));
        // config error
        tbl.push_back(mk(1, 1, 2'd0, 8'h02, 0, 5'b00000, 0, 8'h00));
        tbl.push_back(mk(1, 1, 2'd1, 8'h00, 0, 5'b00000, 0, 8'h00));
        tbl.push_back(mk(1, 1, 2'd0, 8'h01, 0, 5'b00000, 0, 8'h00));
        tbl.push_back(mk(1, 0, 2'd3, 8'h00, 0, 5'b00000, 1, 8'h08));
        // Rsize write while busy is ignored
        tbl.push_back(mk(1, 1, 2'd1, 8'h02, 0, 5'b00000, 0, 8'h00));
        tbl.push_back(mk(1, 1, 2'd0, 8'h05, 0, 5'b00010, 0, 8'h00));
        tbl.push_back(mk(1, 1, 2'd1, 8'h07, 0, 5'b00010, 0, 8'h00));
        tbl.push_back(mk(1, 0, 2'd1, 8'h00, 0, 5'b00010, 1, 8'h02));
        tbl.push_back(mk(1, 0, 2'd3, 8'h00, 0, 5'b00010, 1, 8'h01));
        tbl.push_back(mk(1, 0, 2'd0, 8'h00, 1, 5'b10010, 1, 8'h00));
        tbl.push_back(mk(1, 0, 2'd0, 8'h00, 1, 5'b10110, 1, 8'h00));
        tbl.push_back(mk(1, 0, 2'd0, 8'h00, 1, 5'b10010, 1, 8'h00));
        tbl.push_back(mk(1, 0, 2'd0, 8'h00, 1, 5'b10101, 1, 8'h00));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // abort mid-burst (4x4), abort on the same edge as byte 6
        step(mk(1, 1, 2'd1, 8'h04, 0, 5'b00001, 0, 8'h00), "abort_cfg_size");
        step(mk(1, 1, 2'd2, 8'h04, 0, 5'b00001, 0, 8'h00), "abort_cfg_burst");
        step(mk(1, 1, 2'd0, 8'h01, 0, 5'b00010, 0, 8'h00), "abort_start");
        for (int i = 1; i <= 5; i++)
            step(mk(1, 0, 2'd0, 8'h00, 1, (i == 4) ? 5'b10110 : 5'b10010, 0, 8'h00),
                 $sformatf("abort_byte%0d", i));
        step(mk(1, 1, 2'd0, 8'h02, 1, 5'b01000, 0, 8'h00), "abort_with_byte6");
        step(mk(1, 0, 2'd3, 8'h00, 0, 5'b00000, 1, 8'h00), "abort_status");

        // restart with a byte on the start edge, then a full 16 bytes
        step(mk(1, 1, 2'd0, 8'h01, 1, 5'b01010, 0, 8'h00), "restart_start_rx");
        for (int i = 1; i <= 16; i++) begin
            logic [4:0] f;
            f = {1'b1, 1'b0, (i % 4) == 0, i < 16, i == 16};
            if (i == 8)
                step(mk(1, 1, 2'd3, 8'hFF, 1, f, 0, 8'h00), "restart_byte8_stat_wr");
            else
                step(mk(1, 0, 2'd0, 8'h00, 1, f, 0, 8'h00), $sformatf("restart_byte%0d", i));
        end
        step(mk(1, 0, 2'd3, 8'h00, 0, 5'b00001, 1, 8'h02), "restart_status");

        // reset mid-burst
        step(mk(1, 1, 2'd0, 8'h01, 0, 5'b00010, 0, 8'h00), "rstmid_start");
        step(mk(1, 0, 2'd0, 8'h00, 1, 5'b10010, 0, 8'h00), "rstmid_byte1");
        step(mk(1, 0, 2'd0, 8'h00, 1, 5'b10010, 0, 8'h00), "rstmid_byte2");
        step(mk(0, 1, 2'd0, 8'h01, 1, 5'b00000, 1, 8'h00), "rstmid_reset");
        step(mk(1, 0, 2'd3, 8'h00, 1, 5'b01000, 1, 8'h00), "rstmid_rx_nack");
        step(mk(1, 0, 2'd3, 8'h00, 0, 5'b00000, 1, 8'h04), "rstmid_status");
        step(mk(1, 0, 2'd1, 8'h00, 0, 5'b00000, 1, 8'h00), "rstmid_rsize");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/receiver_controlreg.md
Name: receiver_controlreg

Overview:
- Host-side control/status register block for the receive path of the I2C transceiver. It is the counterpart of the transmitter control register.
- Holds the receive burst configuration (Rsize, Rburst) and runs a small FSM that counts bytes delivered by the I2C receiver engine.
- Per byte, it drives the ACK/NACK decision back to the receiver engine and reports busy/done/overflow status to the host.

Parameters:
- none (all widths fixed at 8-bit data, 2-bit address)

Ports:
- clk  input  1  system clock; all state updates on negedge clk
- rst  input  1  synchronous active-low reset, sampled on negedge clk
- Rdata  input  8  host write data
- Raddr  input  2  register address: 0 control, 1 Rsize, 2 Rburst, 3 status
- Rwrite  input  1  1 = write Rdata to Raddr; 0 = read Raddr into dataout
- dataout  output  8  registered host read data
- rx_valid  input  1  one-cycle pulse from the receiver engine: a byte was received
- rx_ack  output  1  registered one-cycle pulse: byte accepted (drive ACK)
- rx_nack  output  1  registered one-cycle pulse: byte rejected (drive NACK)
- beat_end  output  1  registered one-cycle pulse: last byte of a beat accepted
- busy  output  1  high in RECEIVING
- done  output  1  high in DONE

Behaviour:
- Reset (rst=0 at negedge clk):
  - Rsize=0, Rburst=0, dataout=0, byte_cnt=0, beat_cnt=0.
  - overflow=0, cfg_err=0, rx_ack=0, rx_nack=0, beat_end=0.
  - State=IDLE, so busy=0 and done=0.
  - Reset overrides every other input on the same edge, including reset mid-burst.
- Register map:
  - Addr 1 is Rsize (bytes per beat); addr 2 is Rburst (beats per burst). Both are R/W.
  - Writes to addr 1 or 2 are ignored while busy=1.
  - Addr 0 (control) is write-only; a read returns 0. Bit0 = start, bit1 = abort, bit2 = clear errors. Bits 7:3 are ignored.
  - Addr 3 (status) is read-only; writes are ignored. Bit0 busy, bit1 done, bit2 overflow, bit3 cfg_err, bits 7:4 = 0.
- Read: when Rwrite=0, dataout takes the addressed register on the next negedge (one-edge latency). dataout holds its value while Rwrite=1.
- FSM states: IDLE, RECEIVING, DONE.
  - IDLE/DONE with start=1, Rsize≠0 and Rburst≠0: go to RECEIVING; clear byte_cnt, beat_cnt and overflow.
  - IDLE/DONE with start=1 and (Rsize=0 or Rburst=0): set cfg_err=1; state unchanged.
  - RECEIVING with rx_valid: accept the byte and pulse rx_ack.
    - If byte_cnt = Rsize-1: byte_cnt←0, pulse beat_end.
    - If that byte is also the last of the burst (beat_cnt = Rburst-1): go to DONE.
    - Otherwise beat_cnt←beat_cnt+1.
    - If not the last byte of a beat: byte_cnt←byte_cnt+1.
  - IDLE/DONE with rx_valid: pulse rx_nack and set overflow=1 (sticky).
  - Abort=1 in any state: go to IDLE; clear byte_cnt and beat_cnt; done→0.
  - Clear errors (bit2): overflow←0, cfg_err←0. This may be combined with start/abort in the same write.
  - start while RECEIVING is ignored.
- Total bytes per burst = Rsize×Rburst, up to 255×255. byte_cnt and beat_cnt are 8-bit and never wrap within a burst.
- Simultaneous events:
  - rx_valid on the same edge as a start write: byte gets NACK, overflow is not set, state goes to RECEIVING.
  - rx_valid on the same edge as abort: byte gets NACK, no done, no beat_end, overflow not set.
  - Host write to addr 3 together with rx_valid: the write is ignored and the counting is unaffected.
- rx_ack, rx_nack and beat_end are mutually consistent: never rx_ack and rx_nack together; beat_end only with rx_ack.
- DONE holds until start, abort or reset.

Test Plan:
- Reset: assert rst=0 for 2 edges with junk on all inputs → dataout=0, busy=0, done=0; status read returns 0x00.
- Basic burst: write Rsize=3, Rburst=2, control=0x01, then 6 rx_valid pulses →
  - 6 rx_ack pulses;
  - beat_end on pulses 3 and 6;
  - done=1 after pulse 6;
  - status reads 0x02.
- Overflow: after the basic burst, one more rx_valid → rx_nack pulse, status=0x06. Then write control=0x04 → status=0x02.
- Config error: Rsize=0, write control=0x01 → state stays IDLE, status=0x08. Also check that Rsize written while busy keeps its old value.
- Abort mid-burst: Rsize=4, Rburst=4, start, 5 bytes, abort on the same edge as byte 6 → byte 6 gets rx_nack, busy=0, done=0. A restart then needs a full 16 bytes to reach done.
- Reset mid-burst: rst=0 after 2 of 4 bytes → all outputs return to reset values; the next rx_valid gets NACK with overflow=1.
